// File: rtl/ddr_pkg.sv
// Shared types, default geometry and hit-window helper
// for the DDR arrow lanes.
package ddr_pkg;

  typedef enum logic {
    LANE_IDLE,
    LANE_ACTIVE
  } lane_state_t;

  localparam int SPAWN_Y = 480;
  localparam int STEP    = 4;
  localparam int HIT_Y   = 40;
  localparam int HIT_WIN = 8;

  // One extra bit keeps the distance non-negative.
  function automatic logic in_window(
    input logic [15:0] y,
    input logic [15:0] hit_y,
    input logic [15:0] win
  );
    logic [16:0] d;
    if (y >= hit_y) d = {1'b0, y} - {1'b0, hit_y};
    else            d = {1'b0, hit_y} - {1'b0, y};
    return d <= {1'b0, win};
  endfunction

endpackage

// File: rtl/arrow_lane.sv
// One lane: spawn/scroll FSM, y register, press edge
// detector and registered hit/miss pulses.
module arrow_lane
  import ddr_pkg::*;
#(
  parameter int CORDW   = 10,
  parameter int SPAWN_Y = ddr_pkg::SPAWN_Y,
  parameter int STEP    = ddr_pkg::STEP,
  parameter int HIT_Y   = ddr_pkg::HIT_Y,
  parameter int HIT_WIN = ddr_pkg::HIT_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic             btn,
  output logic [CORDW-1:0] y,
  output logic             active,
  output logic             hit,
  output logic             miss
);

  localparam logic [CORDW-1:0] SPAWN = CORDW'(SPAWN_Y);
  localparam logic [CORDW-1:0] STP   = CORDW'(STEP);

  lane_state_t      state, state_d;
  logic [CORDW-1:0] y_q, y_d;
  logic             btn_q, hit_d, miss_d;
  logic             press, in_win;

  assign press  = btn & ~btn_q;
  assign in_win = in_window(16'(y_q), 16'(HIT_Y),
                            16'(HIT_WIN));

  // A hit judges the pre-move y and suppresses the move.
  always_comb begin
    state_d = state;
    y_d     = y_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state)
      LANE_IDLE: begin
        if (spawn_valid) begin
          state_d = LANE_ACTIVE;
          y_d     = SPAWN;
        end
      end
      LANE_ACTIVE: begin
        if (press && in_win) begin
          hit_d   = 1'b1;
          state_d = LANE_IDLE;
          y_d     = SPAWN;
        end else if (frame) begin
          if (y_q < STP) begin
            miss_d  = 1'b1;
            state_d = LANE_IDLE;
            y_d     = SPAWN;
          end else begin
            y_d = y_q - STP;
          end
        end
      end
      default: begin
        state_d = LANE_IDLE;
        y_d     = SPAWN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LANE_IDLE;
      y_q   <= SPAWN;
      btn_q <= 1'b0;
      hit   <= 1'b0;
      miss  <= 1'b0;
    end else begin
      state <= state_d;
      y_q   <= y_d;
      btn_q <= btn;
      hit   <= hit_d;
      miss  <= miss_d;
    end
  end

  assign y           = y_q;
  assign active      = (state == LANE_ACTIVE);
  assign spawn_ready = (state == LANE_IDLE);

endmodule

// File: rtl/arrow_lane_sched.sv
// Arrow scheduler top: lane array, packed y bus and
// saturating score/streak counters.
module arrow_lane_sched
  import ddr_pkg::*;
#(
  parameter int CORDW       = 10,
  parameter int ARROW_COUNT = 4,
  parameter int SPAWN_Y     = ddr_pkg::SPAWN_Y,
  parameter int STEP        = ddr_pkg::STEP,
  parameter int HIT_Y       = ddr_pkg::HIT_Y,
  parameter int HIT_WIN     = ddr_pkg::HIT_WIN,
  parameter int SCOREW      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         frame_i,
  input  logic [ARROW_COUNT-1:0]       spawn_valid_i,
  output logic [ARROW_COUNT-1:0]       spawn_ready_o,
  input  logic [ARROW_COUNT-1:0]       btn_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       arrow_active_o,
  output logic [ARROW_COUNT-1:0]       hit_o,
  output logic [ARROW_COUNT-1:0]       miss_o,
  output logic [SCOREW-1:0]            score_o,
  output logic [SCOREW-1:0]            streak_o
);

  for (genvar g = 0; g < ARROW_COUNT; g++) begin : g_lane
    arrow_lane #(
      .CORDW   (CORDW),
      .SPAWN_Y (SPAWN_Y),
      .STEP    (STEP),
      .HIT_Y   (HIT_Y),
      .HIT_WIN (HIT_WIN)
    ) u_lane (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .frame       (frame_i),
      .spawn_valid (spawn_valid_i[g]),
      .spawn_ready (spawn_ready_o[g]),
      .btn         (btn_i[g]),
      .y           (arrow_y_o[g*CORDW +: CORDW]),
      .active      (arrow_active_o[g]),
      .hit         (hit_o[g]),
      .miss        (miss_o[g])
    );
  end

  logic [SCOREW-1:0] hit_cnt, score_d, streak_d;
  logic [SCOREW:0]   score_sum, streak_sum;

  // Counters follow the registered pulses by one cycle.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < ARROW_COUNT; i++)
      hit_cnt = hit_cnt + SCOREW'(hit_o[i]);
    score_sum  = {1'b0, score_o} + {1'b0, hit_cnt};
    streak_sum = {1'b0, streak_o} + {1'b0, hit_cnt};
    score_d = score_sum[SCOREW] ? '1
                                : score_sum[SCOREW-1:0];
    if (|miss_o)
      streak_d = '0;
    else if (streak_sum[SCOREW])
      streak_d = '1;
    else
      streak_d = streak_sum[SCOREW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      score_o  <= '0;
      streak_o <= '0;
    end else begin
      score_o  <= score_d;
      streak_o <= streak_d;
    end
  end

endmodule

// File: tb/tb_arrow_lane_sched.sv
// Directed test-plan scenarios plus a random run against
// a lane-rule model of the arrow scheduler.
module tb_arrow_lane_sched;

  localparam int N = 4;
  localparam int W = 10;
  localparam int SMAX = 65535;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame;
  logic [N-1:0]   spawn_v, btn;
  logic [N-1:0]   ready, act, hit, miss;
  logic [W*N-1:0] ypack;
  logic [15:0]    score, streak;

  int errors = 0;
  int checks = 0;

  int       m_y[N];
  bit       m_act[N];
  bit       m_prev[N];
  bit [3:0] m_hit, m_miss;
  int       m_score, m_streak;

  always #5 clk = ~clk;

  arrow_lane_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_i        (frame),
    .spawn_valid_i  (spawn_v),
    .spawn_ready_o  (ready),
    .btn_i          (btn),
    .arrow_y_o      (ypack),
    .arrow_active_o (act),
    .hit_o          (hit),
    .miss_o         (miss),
    .score_o        (score),
    .streak_o       (streak)
  );

  task automatic model_reset();
    for (int l = 0; l < N; l++) begin
      m_y[l] = 480; m_act[l] = 0; m_prev[l] = 0;
    end
    m_hit = 0; m_miss = 0; m_score = 0; m_streak = 0;
  endtask

  task automatic model_step();
    int cnt;
    int d;
    bit press;
    cnt = 0;
    for (int l = 0; l < N; l++) cnt += m_hit[l];
    m_score = (m_score + cnt > SMAX) ? SMAX : m_score + cnt;
    if (m_miss != 0) m_streak = 0;
    else m_streak = (m_streak + cnt > SMAX) ? SMAX
                                            : m_streak + cnt;
    m_hit = 0; m_miss = 0;
    for (int l = 0; l < N; l++) begin
      press = btn[l] && !m_prev[l];
      m_prev[l] = btn[l];
      d = m_y[l] - 40;
      if (d < 0) d = -d;
      if (!m_act[l]) begin
        if (spawn_v[l]) begin m_act[l] = 1; m_y[l] = 480; end
      end else if (press && d <= 8) begin
        m_hit[l] = 1; m_act[l] = 0; m_y[l] = 480;
      end else if (frame) begin
        if (m_y[l] < 4) begin
          m_miss[l] = 1; m_act[l] = 0; m_y[l] = 480;
        end else m_y[l] = m_y[l] - 4;
      end
    end
  endtask

  function automatic logic [W*N-1:0] exp_y();
    logic [W*N-1:0] p;
    for (int l = 0; l < N; l++) p[l*W +: W] = W'(m_y[l]);
    return p;
  endfunction

  function automatic logic [N-1:0] exp_act();
    logic [N-1:0] a;
    for (int l = 0; l < N; l++) a[l] = m_act[l];
    return a;
  endfunction

  // Inputs change at negedge; outputs are read at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    frame = 1'b1;
    repeat (n) tick();
    frame = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame = 0; spawn_v = 0; btn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (act !== 4'b0000 || ready !== 4'b1111
        || hit !== 0 || miss !== 0)
      begin errors++; $display("FAIL reset_flags act=%b rdy=%b hit=%b miss=%b want 0000 1111 0 0", act, ready, hit, miss); end
    checks++;
    if (ypack !== {4{10'd480}} || score !== 0 || streak !== 0)
      begin errors++; $display("FAIL reset_vals y=%h sc=%0d st=%0d want all 480, 0, 0", ypack, score, streak); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spawn();
    spawn_v = 4'b0001;
    tick();
    spawn_v = 4'b0000;
    checks++;
    if (act !== 4'b0001 || ypack[9:0] !== 10'd480
        || ready !== 4'b1110)
      begin errors++; $display("FAIL spawn act=%b y0=%0d rdy=%b want 0001 480 1110", act, ypack[9:0], ready); end
    spawn_v = 4'b0001;
    frames(1);
    spawn_v = 4'b0000;
    checks++;
    if (ypack[9:0] !== 10'd476 || act !== 4'b0001)
      begin errors++; $display("FAIL respawn y0=%0d act=%b want 476 0001", ypack[9:0], act); end
    frames(109);
  endtask

  task automatic test_hit();
    checks++;
    if (ypack[9:0] !== 10'd40)
      begin errors++; $display("FAIL hit_pos y0=%0d want 40", ypack[9:0]); end
    btn = 4'b0001;
    tick();
    checks++;
    if (hit !== 4'b0001 || act[0] !== 1'b0
        || ypack[9:0] !== 10'd480)
      begin errors++; $display("FAIL hit_pulse hit=%b act0=%b y0=%0d want 0001 0 480", hit, act[0], ypack[9:0]); end
    btn = 4'b0000;
    tick();
    checks++;
    if (hit !== 0 || score !== 1 || streak !== 1)
      begin errors++; $display("FAIL hit_score hit=%b sc=%0d st=%0d want 0 1 1", hit, score, streak); end
  endtask

  task automatic test_window();
    spawn_v = 4'b0001; tick(); spawn_v = 0;
    frames(107);
    btn = 4'b0001; tick();
    checks++;
    if (hit !== 0 || act[0] !== 1 || ypack[9:0] !== 10'd52)
      begin errors++; $display("FAIL win_52 hit=%b act0=%b y0=%0d want 0 1 52", hit, act[0], ypack[9:0]); end
    btn = 0; tick();
    frames(1);
    btn = 4'b0001; tick();
    checks++;
    if (hit !== 4'b0001)
      begin errors++; $display("FAIL win_48 hit=%b want 0001", hit); end
    btn = 0;
    spawn_v = 4'b0001; tick(); spawn_v = 0;
    frames(112);
    btn = 4'b0001; tick();
    checks++;
    if (hit !== 4'b0001)
      begin errors++; $display("FAIL win_32 hit=%b want 0001", hit); end
    btn = 0; tick();
    // One hit carried over from test_hit plus these two.
    checks++;
    if (score !== 3 || streak !== 3)
      begin errors++; $display("FAIL win_score sc=%0d st=%0d want 3 3", score, streak); end
    spawn_v = 4'b0001; tick(); spawn_v = 0;
    frames(113);
    btn = 4'b0001; tick();
    checks++;
    if (hit !== 0 || act[0] !== 1 || ypack[9:0] !== 10'd28)
      begin errors++; $display("FAIL win_28 hit=%b act0=%b y0=%0d want 0 1 28", hit, act[0], ypack[9:0]); end
    btn = 0; tick();
  endtask

  task automatic test_miss();
    frames(7);
    checks++;
    if (ypack[9:0] !== 10'd0 || act[0] !== 1 || miss !== 0)
      begin errors++; $display("FAIL miss_y0 y0=%0d act0=%b miss=%b want 0 1 0", ypack[9:0], act[0], miss); end
    frames(1);
    checks++;
    if (miss !== 4'b0001 || act[0] !== 0
        || ypack[9:0] !== 10'd480 || hit !== 0)
      begin errors++; $display("FAIL miss_pulse miss=%b act0=%b y0=%0d hit=%b want 0001 0 480 0", miss, act[0], ypack[9:0], hit); end
    tick();
    checks++;
    if (miss !== 0 || score !== 3 || streak !== 0)
      begin errors++; $display("FAIL miss_score miss=%b sc=%0d st=%0d want 0 3 0", miss, score, streak); end
  endtask

  task automatic test_simultaneous();
    spawn_v = 4'b0001; tick(); spawn_v = 0;
    frames(108);
    frame = 1; btn = 4'b0001; tick();
    frame = 0; btn = 0;
    checks++;
    if (hit !== 4'b0001 || miss !== 0
        || ypack[9:0] !== 10'd480)
      begin errors++; $display("FAIL sim_frame hit=%b miss=%b y0=%0d want 0001 0 480", hit, miss, ypack[9:0]); end
    tick();
    checks++;
    if (score !== 4 || streak !== 1)
      begin errors++; $display("FAIL sim_score sc=%0d st=%0d want 4 1", score, streak); end
    spawn_v = 4'b0110; tick(); spawn_v = 0;
    frames(110);
    btn = 4'b0110; tick();
    btn = 0;
    checks++;
    if (hit !== 4'b0110)
      begin errors++; $display("FAIL dual_hit hit=%b want 0110", hit); end
    tick();
    checks++;
    if (score !== 6 || streak !== 3)
      begin errors++; $display("FAIL dual_score sc=%0d st=%0d want 6 3", score, streak); end
  endtask

  task automatic test_reset_midflight();
    spawn_v = 4'b0011; tick(); spawn_v = 0;
    frames(10);
    spawn_v = 4'b1000; tick(); spawn_v = 0;
    frames(5);
    checks++;
    if (act !== 4'b1011)
      begin errors++; $display("FAIL pre_rst act=%b want 1011", act); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act !== 0 || ready !== 4'b1111
        || ypack !== {4{10'd480}})
      begin errors++; $display("FAIL async_rst act=%b rdy=%b y=%h want 0 1111 all 480", act, ready, ypack); end
    checks++;
    if (score !== 0 || streak !== 0 || hit !== 0 || miss !== 0)
      begin errors++; $display("FAIL async_cnt sc=%0d st=%0d hit=%b miss=%b want 0 0 0 0", score, streak, hit, miss); end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    spawn_v = 4'b0100; tick(); spawn_v = 0;
    checks++;
    if (act !== 4'b0100 || hit !== 0 || miss !== 0)
      begin errors++; $display("FAIL post_rst act=%b hit=%b miss=%b want 0100 0 0", act, hit, miss); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      spawn_v = 4'($urandom) & 4'($urandom) & 4'($urandom);
      btn     = btn ^ (4'($urandom) & 4'($urandom));
      frame   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (ypack !== exp_y())
        begin errors++; $display("FAIL rnd_y c=%0d got=%h want=%h", c, ypack, exp_y()); end
      checks++;
      if (act !== exp_act() || ready !== ~exp_act()
          || hit !== m_hit || miss !== m_miss)
        begin errors++; $display("FAIL rnd_flags c=%0d act=%b rdy=%b hit=%b miss=%b want %b %b %b %b", c, act, ready, hit, miss, exp_act(), ~exp_act(), m_hit, m_miss); end
      checks++;
      if (score !== 16'(m_score) || streak !== 16'(m_streak))
        begin errors++; $display("FAIL rnd_cnt c=%0d sc=%0d st=%0d want %0d %0d", c, score, streak, m_score, m_streak); end
    end
    spawn_v = 0; btn = 0; frame = 0;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit();
    test_window();
    test_miss();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
